// File: rtl/ebn_if.sv
// rtl/ebn_if.sv - valid/ready handshake bundle for the ebn elastic buffer
interface ebn_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] t_0_data;
    logic             t_0_valid;
    logic             t_0_ready;
    logic [WIDTH-1:0] i_0_data;
    logic             i_0_valid;
    logic             i_0_ready;
    logic [CW-1:0]    count;

    modport slave (
        input  t_0_data, t_0_valid, i_0_ready,
        output t_0_ready, i_0_data, i_0_valid, count
    );

    modport master (
        output t_0_data, t_0_valid, i_0_ready,
        input  t_0_ready, i_0_data, i_0_valid, count
    );
endinterface

// File: rtl/ebn.sv
// rtl/ebn.sv - parametrised valid/ready FIFO stage with optional empty bypass
// t_0_ready is a function of registered occupancy only, breaking the ready path.
module ebn #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0
) (
    input  logic  clk,
    input  logic  reset,
    ebn_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             empty, full, byp;
    logic             t_ready, i_valid;
    logic [WIDTH-1:0] i_data;
    logic             push, pop, thru, wr_en, rd_en;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        byp      = (BYPASS != 0) && empty;
        t_ready  = !full;
        i_valid  = byp ? bus.t_0_valid : !empty;
        i_data   = byp ? bus.t_0_data : mem_q[rd_ptr_q];
        push     = bus.t_0_valid && t_ready;
        pop      = i_valid && bus.i_0_ready;
        // a bypass transfer moves the word straight through and leaves storage untouched
        thru     = byp && push && pop;
        wr_en    = push && !thru;
        rd_en    = pop && !thru;

        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage carries no reset; stale contents are unreachable once count is 0
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= bus.t_0_data;
        end
    end

    assign bus.t_0_ready = t_ready;
    assign bus.i_0_valid = i_valid;
    assign bus.i_0_data  = i_data;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_ebn.sv
// tb/tb_ebn.sv - bench for ebn: four configurations against a queue model plus directed literals
module tb_ebn;
    localparam int DEP [4] = '{4, 3, 2, 1};
    localparam int BYP [4] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] td  [4];
    logic       tv  [4];
    logic       ir  [4];
    logic       tr  [4];
    logic       iv  [4];
    logic [7:0] idt [4];
    logic [2:0] cnt [4];

    int checks = 0;
    int errors = 0;
    logic [7:0] mq [4][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : u
        ebn_if #(.WIDTH(8), .DEPTH(DEP[g])) bus ();
        assign bus.t_0_data  = td[g];
        assign bus.t_0_valid = tv[g];
        assign bus.i_0_ready = ir[g];
        assign tr[g]  = bus.t_0_ready;
        assign iv[g]  = bus.i_0_valid;
        assign idt[g] = bus.i_0_data;
        assign cnt[g] = 3'(bus.count);
        ebn #(.WIDTH(8), .DEPTH(DEP[g]), .BYPASS(BYP[g])) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, g, $time, act, exp);
        end
    endtask

    // model: occupancy is the queue size, head is the oldest word
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            int n;
            bit et, ev, byp, push, pop;
            logic [7:0] ed;
            if (reset) mq[g].delete();
            n   = mq[g].size();
            et  = (n != DEP[g]);
            byp = (BYP[g] != 0) && (n == 0);
            ev  = byp ? tv[g] : (n != 0);
            ed  = byp ? td[g] : ((n != 0) ? mq[g][0] : 8'h00);
            chk("model_t_ready", g, 32'(tr[g]), 32'(et));
            chk("model_count", g, 32'(cnt[g]), 32'(n));
            chk("model_i_valid", g, 32'(iv[g]), 32'(ev));
            if (ev) chk("model_i_data", g, 32'(idt[g]), 32'(ed));
            if (!reset) begin
                push = tv[g] && et;
                pop  = ev && ir[g];
                if (!(byp && push && pop)) begin
                    if (pop)  void'(mq[g].pop_front());
                    if (push) mq[g].push_back(td[g]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int sent, rcv, c;
        for (int g = 0; g < 4; g++) begin
            td[g] = 8'h00; tv[g] = 1'b0; ir[g] = 1'b0;
        end
        #2;
        chk("reset_t_ready", 0, 32'(tr[0]), 32'd1);
        chk("reset_count", 0, 32'(cnt[0]), 32'd0);
        chk("reset_i_valid", 0, 32'(iv[0]), 32'd0);
        step(); step();
        reset = 1'b0;

        // fill then drain, DEPTH=4
        for (int k = 0; k < 4; k++) begin
            td[0] = 8'(8'h11 * (k + 1)); tv[0] = 1'b1;
            step();
        end
        tv[0] = 1'b0;
        chk("fill_count", 0, 32'(cnt[0]), 32'd4);
        chk("fill_t_ready", 0, 32'(tr[0]), 32'd0);
        ir[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_valid", 0, 32'(iv[0]), 32'd1);
            chk("drain_data", 0, 32'(idt[0]), 32'(8'h11 * (k + 1)));
            step();
        end
        chk("drain_count", 0, 32'(cnt[0]), 32'd0);

        // full with simultaneous pop: push refused, then accepted
        ir[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            td[0] = 8'(8'h11 * (k + 1)); tv[0] = 1'b1;
            step();
        end
        td[0] = 8'h55; ir[0] = 1'b1;
        #1;
        chk("fullpop_t_ready", 0, 32'(tr[0]), 32'd0);
        chk("fullpop_count4", 0, 32'(cnt[0]), 32'd4);
        step();
        chk("fullpop_count3a", 0, 32'(cnt[0]), 32'd3);
        chk("fullpop_ready_back", 0, 32'(tr[0]), 32'd1);
        step();
        chk("fullpop_count3b", 0, 32'(cnt[0]), 32'd3);
        tv[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fullpop_order", 0, 32'(idt[0]), 32'(k == 2 ? 8'h55 : 8'(8'h11 * (k + 3))));
            step();
        end
        chk("fullpop_empty", 0, 32'(cnt[0]), 32'd0);

        // reset mid-stream with two words stored
        ir[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            td[0] = 8'(8'hE0 + k); tv[0] = 1'b1;
            step();
        end
        tv[0] = 1'b0;
        chk("pre_reset_count", 0, 32'(cnt[0]), 32'd2);
        reset = 1'b1;
        #1;
        chk("midreset_count", 0, 32'(cnt[0]), 32'd0);
        chk("midreset_t_ready", 0, 32'(tr[0]), 32'd1);
        chk("midreset_i_valid", 0, 32'(iv[0]), 32'd0);
        step();
        reset = 1'b0;
        ir[0] = 1'b1;
        step(); step();
        chk("post_reset_i_valid", 0, 32'(iv[0]), 32'd0);
        ir[0] = 1'b0;

        // wrap, DEPTH=3, stalls on both sides
        sent = 0; rcv = 0; c = 0;
        while (rcv < 10 && c < 120) begin
            tv[1] = (sent < 10) && ((c % 3) != 2);
            td[1] = 8'(sent);
            ir[1] = ((c % 4) != 0) && ((c % 7) != 3);
            #1;
            if (tv[1] && tr[1]) sent++;
            if (iv[1] && ir[1]) begin
                chk("wrap_order", 1, 32'(idt[1]), 32'(rcv));
                rcv++;
            end
            if (cnt[1] > 3'd3) chk("wrap_count_max", 1, 32'(cnt[1]), 32'd3);
            step();
            c++;
        end
        tv[1] = 1'b0; ir[1] = 1'b0;
        chk("wrap_received", 1, 32'(rcv), 32'd10);

        // bypass, DEPTH=2
        td[2] = 8'hA5; tv[2] = 1'b1; ir[2] = 1'b1;
        #1;
        chk("byp_valid", 2, 32'(iv[2]), 32'd1);
        chk("byp_data", 2, 32'(idt[2]), 32'hA5);
        step();
        chk("byp_count0", 2, 32'(cnt[2]), 32'd0);
        ir[2] = 1'b0;
        step();
        tv[2] = 1'b0; td[2] = 8'h00;
        chk("byp_count1", 2, 32'(cnt[2]), 32'd1);
        #1;
        chk("byp_hold_valid", 2, 32'(iv[2]), 32'd1);
        chk("byp_hold_data", 2, 32'(idt[2]), 32'hA5);
        step();
        chk("byp_hold_data2", 2, 32'(idt[2]), 32'hA5);
        ir[2] = 1'b1;
        step();
        chk("byp_drained", 2, 32'(cnt[2]), 32'd0);
        ir[2] = 1'b0;

        // DEPTH=1: one word per two cycles
        sent = 0; rcv = 0; c = 0;
        ir[3] = 1'b1;
        while (rcv < 10 && c < 60) begin
            tv[3] = (sent < 10);
            td[3] = 8'(8'h30 + sent);
            #1;
            if (tv[3] && tr[3]) sent++;
            if (iv[3] && ir[3]) begin
                chk("d1_order", 3, 32'(idt[3]), 32'(8'h30 + rcv));
                rcv++;
            end
            step();
            c++;
        end
        tv[3] = 1'b0; ir[3] = 1'b0;
        chk("d1_cycles", 3, 32'(c), 32'd20);
        chk("d1_received", 3, 32'(rcv), 32'd10);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
